// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and data requesters.
// Data has priority; fetch is forced after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter int AWIDTH     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_gnt,
  input  logic              i_kill,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       kill_q, kill_d;

  logic slot, d_take, i_take, i_done, d_done;

  always_comb begin
    i_done = rst && (state_q == BUSY_I) && (cnt_q == 3'd1);
    d_done = rst && (state_q == BUSY_D) && (cnt_q == 3'd1);
    slot   = rst && ((state_q == IDLE) || i_done || d_done);
    d_take = slot && d_req && !((starve_q == SMAX) && i_req);
    i_take = slot && i_req && !d_take;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      starve_q <= 4'd0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      kill_q   <= kill_d;
    end
  end

  always_comb begin
    state_d  = IDLE;
    cnt_d    = 3'd0;
    starve_d = starve_q;
    kill_d   = kill_q;
    if (d_take) begin
      state_d = BUSY_D;
      cnt_d   = LAT;
    end else if (i_take) begin
      state_d = BUSY_I;
      cnt_d   = LAT;
    end else begin
      case (state_q)
        BUSY_I, BUSY_D: begin
          if (cnt_q > 3'd1) begin
            state_d = state_q;
            cnt_d   = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
    if (!i_req || i_take)
      starve_d = 4'd0;
    else if (d_take && starve_q != SMAX)
      starve_d = starve_q + 4'd1;
    // A kill in a fetch grant cycle also covers the fetch just issued
    if (i_done)
      kill_d = 1'b0;
    if (i_kill && (i_take || (state_q == BUSY_I && !i_done)))
      kill_d = 1'b1;
  end

  always_comb begin
    i_gnt     = i_take;
    d_gnt     = d_take;
    mem_en    = i_take || d_take;
    mem_we    = d_take ? d_we : 4'd0;
    mem_addr  = d_take ? d_addr : (i_take ? i_addr : '0);
    mem_wdata = mem_en ? d_wdata : 32'd0;
    i_rvalid  = i_done && !kill_q && !i_kill;
    i_rdata   = i_rvalid ? mem_rdata : 32'd0;
    d_rvalid  = d_done;
    d_rdata   = d_done ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Instance g runs with MEM_LAT = g+1; all share the same inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_kill = 1'b0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        ig [3];
  logic        ir [3];
  logic        dg [3];
  logic        dr [3];
  logic        me [3];
  logic [31:0] ird [3];
  logic [31:0] drd [3];
  logic [3:0]  mwe [3];
  logic [31:0] mad [3];
  logic [31:0] mwd [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .MEM_LAT(g + 1),
      .STARVE_MAX(4),
      .AWIDTH(32)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .i_req(i_req),
      .i_addr(i_addr),
      .i_gnt(ig[g]),
      .i_kill(i_kill),
      .i_rvalid(ir[g]),
      .i_rdata(ird[g]),
      .d_req(d_req),
      .d_addr(d_addr),
      .d_we(d_we),
      .d_wdata(d_wdata),
      .d_gnt(dg[g]),
      .d_rvalid(dr[g]),
      .d_rdata(drd[g]),
      .mem_en(me[g]),
      .mem_we(mwe[g]),
      .mem_addr(mad[g]),
      .mem_wdata(mwd[g]),
      .mem_rdata(mem_rdata)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    tick();
    rst = 1'b0;
    i_req = 0; d_req = 0; i_kill = 0;
    d_we = 0; mem_rdata = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [136:0] v;
    tick();
    rst = 1'b0;
    i_req = 1; d_req = 1;
    i_addr = 32'h10; d_addr = 32'h20;
    d_we = 4'hF; d_wdata = 32'h55;
    mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      v = {ig[0], dg[0], ir[0], dr[0], me[0],
           mwe[0], mad[0], mwd[0], ird[0], drd[0]};
      checks++;
      if (v !== '0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=0", k, v);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ig[0], dg[0], me[0]} !== 3'b011) begin
      failures++;
      $display("FAIL reset_release got=%b want=011",
               {ig[0], dg[0], me[0]});
    end
    i_req = 0; d_req = 0; d_we = 0;
  endtask

  task automatic test_single_fetch();
    reset_all();
    i_req = 1; i_addr = 32'h100;
    #1;
    checks++;
    if ({ig[1], me[1], mwe[1]} !== 6'b110000 || mad[1] !== 32'h100) begin
      failures++;
      $display("FAIL fetch_grant got=%b addr=%h want=110000 addr=100",
               {ig[1], me[1], mwe[1]}, mad[1]);
    end
    tick();
    i_req = 0;
    #1;
    checks++;
    if ({ir[1], ig[1], me[1]} !== 3'b000) begin
      failures++;
      $display("FAIL fetch_wait got=%b want=000", {ir[1], ig[1], me[1]});
    end
    tick();
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (ir[1] !== 1'b1 || ird[1] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL fetch_data got=%b/%h want=1/deadbeef", ir[1], ird[1]);
    end
    tick();
    #1;
    checks++;
    if ({ir[1], me[1]} !== 2'b00 || ird[1] !== 32'h0) begin
      failures++;
      $display("FAIL fetch_idle got=%b/%h want=00/0",
               {ir[1], me[1]}, ird[1]);
    end
  endtask

  task automatic test_contention();
    logic [3:0] want;
    reset_all();
    i_req = 1; d_req = 1; d_we = 0;
    i_addr = 32'h400; d_addr = 32'h800;
    mem_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 6; k++) begin
      #1;
      want = {(k != 4), (k == 4), (k >= 1 && k <= 4), (k == 5)};
      checks++;
      if ({dg[0], ig[0], dr[0], ir[0]} !== want) begin
        failures++;
        $display("FAIL contention slot=%0d dg,ig,dr,ir got=%b want=%b",
                 k, {dg[0], ig[0], dr[0], ir[0]}, want);
      end
      tick();
    end
    i_req = 0; d_req = 0;
  endtask

  task automatic test_store();
    reset_all();
    d_req = 1; d_addr = 32'h2004;
    d_we = 4'b0011; d_wdata = 32'h1234_ABCD;
    #1;
    checks++;
    if ({dg[0], me[0], mwe[0]} !== 6'b110011 || mad[0] !== 32'h2004 ||
        mwd[0] !== 32'h1234_ABCD) begin
      failures++;
      $display("FAIL store_issue got=%b %h %h want=110011 2004 1234abcd",
               {dg[0], me[0], mwe[0]}, mad[0], mwd[0]);
    end
    tick();
    d_req = 0; d_we = 0;
    #1;
    checks++;
    if (dr[0] !== 1'b1) begin
      failures++;
      $display("FAIL store_done got=%b want=1", dr[0]);
    end
    tick();
    #1;
    checks++;
    if (dr[0] !== 1'b0) begin
      failures++;
      $display("FAIL store_pulse got=%b want=0", dr[0]);
    end
  endtask

  task automatic test_kill();
    reset_all();
    i_req = 1; i_addr = 32'h40;
    #1;
    checks++;
    if (ig[2] !== 1'b1) begin
      failures++;
      $display("FAIL kill_grant got=%b want=1", ig[2]);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      i_req = (k == 3);
      i_addr = 32'h80;
      i_kill = (k == 1);
      mem_rdata = 32'h1111_2222;
      #1;
      checks++;
      if (ir[2] !== 1'b0) begin
        failures++;
        $display("FAIL kill_suppress t0+%0d got=%b want=0", k, ir[2]);
      end
    end
    checks++;
    if (ig[2] !== 1'b1 || mad[2] !== 32'h80) begin
      failures++;
      $display("FAIL kill_regrant got=%b/%h want=1/80", ig[2], mad[2]);
    end
    tick();
    i_req = 0;
    tick();
    tick();
    mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (ir[2] !== 1'b1 || ird[2] !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL kill_after got=%b/%h want=1/cafef00d", ir[2], ird[2]);
    end
  endtask

  task automatic test_kill_same_cycle();
    reset_all();
    i_req = 1; i_addr = 32'h44;
    tick();
    i_req = 0;
    tick();
    i_kill = 1; mem_rdata = 32'h7777_7777;
    #1;
    checks++;
    if (ir[1] !== 1'b0 || ird[1] !== 32'h0) begin
      failures++;
      $display("FAIL kill_same got=%b/%h want=0/0", ir[1], ird[1]);
    end
    tick();
    i_kill = 0;
    i_req = 1;
    #1;
    checks++;
    if (ig[1] !== 1'b1) begin
      failures++;
      $display("FAIL kill_same_next got=%b want=1", ig[1]);
    end
    tick();
    i_req = 0;
    tick();
    #1;
    checks++;
    if (ir[1] !== 1'b1) begin
      failures++;
      $display("FAIL kill_cleared got=%b want=1", ir[1]);
    end
  endtask

  task automatic test_reset_mid();
    reset_all();
    d_req = 1; d_addr = 32'h300;
    #1;
    checks++;
    if (dg[2] !== 1'b1) begin
      failures++;
      $display("FAIL rmid_grant got=%b want=1", dg[2]);
    end
    tick();
    d_req = 0; rst = 0;
    #1;
    checks++;
    if ({dr[2], dg[2], me[2]} !== 3'b000) begin
      failures++;
      $display("FAIL rmid_reset got=%b want=000", {dr[2], dg[2], me[2]});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      rst = 1;
      #1;
      checks++;
      if (dr[2] !== 1'b0) begin
        failures++;
        $display("FAIL rmid_norvalid cyc=%0d got=%b want=0", k, dr[2]);
      end
    end
    tick();
    d_req = 1;
    #1;
    checks++;
    if (dg[2] !== 1'b1) begin
      failures++;
      $display("FAIL rmid_regrant got=%b want=1", dg[2]);
    end
    d_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_kill();
    test_kill_same_cycle();
    test_reset_mid();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
